uart_tx: RTL and testbench

- Transmit half of the team UART: serialises one user byte per valid/ready handshake onto the idle-high TX line.
- Frame format: start, data (LSB first), optional parity, stop.
- Frame parameters and parity encoding match the matching receiver, so uart_tx output can loop straight into that receiver.
- Sits between user logic (byte stream) and the pad/IO buffer.

---
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start / LSB-first data / optional parity / stop on an idle-high line.
// Defining UART_TX_DBUF_EN adds a one-entry holding register so frames can run back to back.
module uart_tx #(
  parameter int P_UART_BUADRATE    = 115200,
  parameter int P_SYSTEM_CLK       = 100000000,
  parameter int P_UART_START_WIDTH = 1,
  parameter int P_UART_DATA_WIDTH  = 8,
  parameter int P_UART_STOP_WIDTH  = 1,
  parameter int P_UART_CHECK_WIDTH = 1,
  parameter int P_UART_CHECK       = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx
);

  localparam int          P_DIV      = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam logic [15:0] DIV_LAST   = 16'(P_DIV - 1);
  localparam logic [7:0]  START_LAST = 8'(P_UART_START_WIDTH - 1);
  localparam logic [7:0]  DATA_LAST  = 8'(P_UART_DATA_WIDTH - 1);
  localparam logic [7:0]  CHECK_LAST = 8'(P_UART_CHECK_WIDTH - 1);
  localparam logic [7:0]  STOP_LAST  = 8'(P_UART_STOP_WIDTH - 1);
  // Unknown parity codes fall back to "no parity".
  localparam bit          CHECK_EN   = (P_UART_CHECK == 1) || (P_UART_CHECK == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]                   state;
  logic [15:0]                  baud_cnt;
  logic [7:0]                   bit_cnt;
  logic [P_UART_DATA_WIDTH-1:0] shift_reg;
  logic                         parity_bit;

  logic                         hs;
  logic                         bit_end;
  logic                         frame_end;
  logic                         start_frame;
  logic                         ready_nxt;
  logic [P_UART_DATA_WIDTH-1:0] load_data;
`ifdef UART_TX_DBUF_EN
  logic                         buf_full;
  logic                         buf_full_nxt;
  logic [P_UART_DATA_WIDTH-1:0] buf_data;
`endif

  function automatic logic parity_of(input logic [P_UART_DATA_WIDTH-1:0] d);
    parity_of = (P_UART_CHECK == 2) ? ~(^d) : (^d);
  endfunction

  assign hs        = i_user_tx_valid && o_user_tx_ready;
  assign bit_end   = (baud_cnt == DIV_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);

  always_comb begin
`ifdef UART_TX_DBUF_EN
    load_data    = buf_full ? buf_data : i_user_tx_data;
    // A full buffer, or a byte arriving on the very last stop clock, chains straight into START.
    start_frame  = ((state == S_IDLE) && hs) || (frame_end && (buf_full || hs));
    buf_full_nxt = buf_full;
    if (frame_end)
      buf_full_nxt = 1'b0;
    else if (hs && (state != S_IDLE))
      buf_full_nxt = 1'b1;
    ready_nxt    = !buf_full_nxt;
`else
    load_data    = i_user_tx_data;
    start_frame  = (state == S_IDLE) && hs;
    ready_nxt    = (state == S_IDLE) ? !hs : frame_end;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      o_uart_tx       <= 1'b1;
      o_user_tx_ready <= 1'b0;
      baud_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      parity_bit      <= 1'b0;
`ifdef UART_TX_DBUF_EN
      buf_full        <= 1'b0;
      buf_data        <= '0;
`endif
    end else begin
      o_user_tx_ready <= ready_nxt;
`ifdef UART_TX_DBUF_EN
      buf_full        <= buf_full_nxt;
      if (hs && (state != S_IDLE) && !frame_end)
        buf_data <= i_user_tx_data;
`endif
      if (start_frame) begin
        state      <= S_START;
        o_uart_tx  <= 1'b0;
        baud_cnt   <= '0;
        bit_cnt    <= '0;
        shift_reg  <= load_data;
        parity_bit <= parity_of(load_data);
      end else if (state == S_IDLE) begin
        o_uart_tx <= 1'b1;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        // Bit-period boundary: the next line level is registered here.
        baud_cnt <= '0;
        case (state)
          S_START: begin
            if (bit_cnt == START_LAST) begin
              bit_cnt   <= '0;
              state     <= S_DATA;
              o_uart_tx <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          S_DATA: begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (CHECK_EN) begin
                state     <= S_CHECK;
                o_uart_tx <= parity_bit;
              end else begin
                state     <= S_STOP;
                o_uart_tx <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 8'd1;
              o_uart_tx <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
          S_CHECK: begin
            if (bit_cnt == CHECK_LAST) begin
              bit_cnt   <= '0;
              state     <= S_STOP;
              o_uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          S_STOP: begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt   <= '0;
              state     <= S_IDLE;
              o_uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          default: begin
            state     <= S_IDLE;
            o_uart_tx <= 1'b1;
            bit_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: even / odd / no-parity instances at 4 clocks per bit.
module tb_uart_tx;

`ifdef UART_TX_DBUF_EN
  localparam logic BUSY_RDY = 1'b1;
`else
  localparam logic BUSY_RDY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [7:0] data_v [3];

  int tests = 0;
  int fails = 0;

  uart_tx #(.P_UART_BUADRATE(1), .P_SYSTEM_CLK(4), .P_UART_CHECK(1)) u_even (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_v[0]), .i_user_tx_valid(valid[0]),
    .o_user_tx_ready(ready[0]), .o_uart_tx(tx[0]));
  uart_tx #(.P_UART_BUADRATE(1), .P_SYSTEM_CLK(4), .P_UART_CHECK(2)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_v[1]), .i_user_tx_valid(valid[1]),
    .o_user_tx_ready(ready[1]), .o_uart_tx(tx[1]));
  uart_tx #(.P_UART_BUADRATE(1), .P_SYSTEM_CLK(4), .P_UART_CHECK(0)) u_none (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_v[2]), .i_user_tx_valid(valid[2]),
    .o_user_tx_ready(ready[2]), .o_uart_tx(tx[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake one byte on instance s; optionally keep valid asserted afterwards.
  task automatic handshake(input int s, input logic [7:0] d, input bit hold, input string tag);
    check({tag, "_hs_ready"}, 32'(ready[s]), 32'd1);
    data_v[s] = d;
    valid[s]  = 1'b1;
    tick();
    if (!hold) valid[s] = 1'b0;
    check({tag, "_busy_ready"}, 32'(ready[s]), 32'(BUSY_RDY));
  endtask

  // Sample nbits line bits, 4 clocks each; exp[i] is line bit i. Optionally inject a
  // second handshake at clock inj of the frame.
  task automatic run_frame(input int s, input int nbits, input logic [15:0] exp,
                           input string tag, input int inj, input logic [7:0] inj_d);
    logic [3:0] v;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i * 4 + c == inj) begin
          data_v[s] = inj_d;
          valid[s]  = 1'b1;
        end
        v[c] = tx[s];
        tick();
        if (i * 4 + c == inj) valid[s] = 1'b0;
      end
      check($sformatf("%s_bit%0d", tag, i), 32'(v), 32'({4{exp[i]}}));
    end
  endtask

  task automatic end_check(input int s, input string tag);
    check({tag, "_end_tx"}, 32'(tx[s]), 32'd1);
    check({tag, "_end_ready"}, 32'(ready[s]), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    valid     = 3'b000;
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    data_v[2] = 8'h00;

    // Reset behaviour and release.
    tick();
    tick();
    check("rst_tx", 32'(tx), 32'h7);
    check("rst_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    tick();
    check("rel_ready", 32'(ready), 32'h7);
    tick();
    tick();
    tick();
    check("idle_tx", 32'(tx), 32'h7);

    // Even parity 0xA5.
    handshake(0, 8'hA5, 1'b0, "a5");
    run_frame(0, 11, 16'h054A, "a5", -1, 8'h00);
    end_check(0, "a5");

    // Odd parity 0x01, and no-parity 0x01 (10-bit frame).
    handshake(1, 8'h01, 1'b0, "odd01");
    run_frame(1, 11, 16'h0402, "odd01", -1, 8'h00);
    end_check(1, "odd01");
    handshake(2, 8'h01, 1'b0, "none01");
    run_frame(2, 10, 16'h0202, "none01", -1, 8'h00);
    end_check(2, "none01");

`ifndef UART_TX_DBUF_EN
    // Valid held: 0x55 then 0xAA, data changed right after the first handshake.
    handshake(0, 8'h55, 1'b1, "b2b1");
    data_v[0] = 8'hAA;
    run_frame(0, 11, 16'h04AA, "b2b1", -1, 8'h00);
    end_check(0, "b2b_gap");
    tick();
    check("b2b2_busy_ready", 32'(ready[0]), 32'd0);
    run_frame(0, 11, 16'h0554, "b2b2", -1, 8'h00);
    valid[0] = 1'b0;
    end_check(0, "b2b2");
`endif

    // Asynchronous reset at clock 10 of a frame, then a clean 0x3C frame.
    handshake(0, 8'hA5, 1'b0, "rstmid");
    for (int k = 0; k < 10; k++) tick();
    check("rstmid_pre_tx", 32'(tx[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_async_tx", 32'(tx[0]), 32'd1);
    check("rstmid_async_ready", 32'(ready[0]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_rel", {29'd0, ready}, 32'h7);
    handshake(0, 8'h3C, 1'b0, "x3c");
    run_frame(0, 11, 16'h0478, "x3c", -1, 8'h00);
    end_check(0, "x3c");

`ifdef UART_TX_DBUF_EN
    // Second byte handshaken during frame 1 DATA: frame 2 follows with no idle clock.
    handshake(0, 8'h55, 1'b0, "db1");
    run_frame(0, 11, 16'h04AA, "db1", 8, 8'hAA);
    check("db_chain_tx", 32'(tx[0]), 32'd0);
    check("db_chain_ready", 32'(ready[0]), 32'd1);
    run_frame(0, 11, 16'h0554, "db2", -1, 8'h00);
    end_check(0, "db2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
